dispatch_unit: RTL and testbench
================================

// Module: dispatch_unit
// PURPOSE
// Two-wide dispatch stage of the out-of-order RISC-V core, sitting between RENAME and the ROB/reservation stations.
// Each cycle it registers up to two renamed instructions and allocates consecutive ROB indices for them.
// It resolves source-operand readiness from a physical-register busy table, with intra-bundle and wakeup bypass.
// Outputs are one ROB row and one RS row per slot.
// PARAMETERS
// NUM_PREGS  64  physical registers; preg index width PW = $clog2(NUM_PREGS)
// ROB_DEPTH  16  ROB entries, power of two; index width RW = $clog2(ROB_DEPTH)
// PORTS
// i_clk          in   1          single clock, all state rising-edge
// i_rst_n        in   1          asynchronous, active-low reset
// i_stall        in   1          backend full: accept nothing this cycle
// i_rename_data  in   2 x rename_struct  slot0 = older instruction
// i_wb_valid     in   2          completion wakeup valid, per writeback port
// i_wb_preg      in   2 x PW     preg written by each writeback port
// o_rob_rows     out  2 x rob_row_struct  registered ROB allocation rows
// o_rs_rows      out  2 x rs_row_struct   registered RS insert rows
// o_rob_tail     out  RW         current allocation pointer
// BEHAVIOUR
// Interface: one clock, i_clk; reset i_rst_n is asynchronous, active-low.
// rename_struct fields: valid, op[5:0], fu[1:0], arch_rd[4:0], writes_rd, prd, old_prd, prs1, prs2 (PW each), uses_rs1, uses_rs2, uses_imm, imm[31:0].
// rob_row_struct fields: valid, rob_idx, arch_rd, prd, old_prd, writes_rd, done (always 0 on dispatch).
// rs_row_struct fields: valid, rob_idx, op, fu, prd, prs1, rs1_rdy, prs2, rs2_rdy, uses_imm, imm.
// Reset (async): all output valid bits 0; other output fields 0; tail 0; busy table all 0 (every preg ready).
// Latency: one cycle. Inputs sampled at edge N appear on outputs after edge N; outputs hold until the next edge.
// Stall: if i_stall=1 at an edge:
//   - outputs' valid bits go 0; tail and busy table do not change;
//   - upstream is responsible for holding its data.
//   Wakeups are still applied during stall.
// ROB allocation, per edge without stall:
//   - slot0.rob_idx = tail;
//   - slot1.rob_idx = tail+1 if slot0.valid, else tail;
//   - tail += number of valid slots (0..2), modulo ROB_DEPTH; wraps 15 -> 0 with default parameters.
// Invalid slots drive valid=0 and do not consume an index. The remaining fields of an invalid slot are don't-care; drive 0.
// Source ready, in priority order:
//   - not used (uses_rsX=0) or preg 0 -> ready;
//   - slot1 source == slot0.prd with slot0.valid & writes_rd -> NOT ready (intra-bundle dependence);
//   - matches any i_wb_preg with i_wb_valid this cycle -> ready (wakeup bypass);
//   - otherwise ready = !busy[preg].
// Busy update, per edge:
//   - clear busy for each valid wakeup preg;
//   - then set busy[prd] for each valid, non-stalled slot with writes_rd and prd != 0;
//   - set wins over clear for the same preg.
// Preg 0 is never marked busy.
// ROB/RS row fields not listed above copy straight from the matching rename field.
// TESTING
// Reset, then a bundle of two valid independent instructions (prs1=3, prs2=4, prd=10/11) -> rob_idx 0/1, all srcs ready, tail=2, busy[10], busy[11] set.
// Slot1 reads prs1=10 while slot0 writes prd=10 -> slot1 rs1_rdy=0; a later reader of 10 is not ready until i_wb_valid with i_wb_preg=10, then ready.
// A reader of preg 12 arrives in the same cycle as the wakeup of 12 -> rs1_rdy=1; a wakeup of 12 in the same cycle as a new allocation of prd=12 -> busy[12] stays 1.
// Run eight 2-wide bundles, then one slot0-only bundle -> the indices wrap 14,15,0; tail goes 0 -> 1; a slot0-invalid/slot1-valid bundle takes index = tail.
// i_stall=1 with valid inputs -> output valids 0 and tail/busy unchanged; deassert i_rst_n mid-stream -> outputs invalid immediately, tail=0, busy cleared.

Source files
------------

// File: rtl/dispatch_unit_if.sv
// Shared payload types and the rename-to-backend bundle of the two-wide dispatch stage.
// The package lives here so the interface and the dispatch unit see one definition.
package dispatch_unit_pkg;
    localparam int unsigned NUM_PREGS = 64;
    localparam int unsigned ROB_DEPTH = 16;
    localparam int unsigned PW        = $clog2(NUM_PREGS);
    localparam int unsigned RW        = $clog2(ROB_DEPTH);

    typedef struct packed {
        logic          valid;
        logic [5:0]    op;
        logic [1:0]    fu;
        logic [4:0]    arch_rd;
        logic          writes_rd;
        logic [PW-1:0] prd;
        logic [PW-1:0] old_prd;
        logic [PW-1:0] prs1;
        logic [PW-1:0] prs2;
        logic          uses_rs1;
        logic          uses_rs2;
        logic          uses_imm;
        logic [31:0]   imm;
    } rename_t;

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rob_idx;
        logic [4:0]    arch_rd;
        logic [PW-1:0] prd;
        logic [PW-1:0] old_prd;
        logic          writes_rd;
        logic          done;
    } rob_row_t;

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rob_idx;
        logic [5:0]    op;
        logic [1:0]    fu;
        logic [PW-1:0] prd;
        logic [PW-1:0] prs1;
        logic          rs1_rdy;
        logic [PW-1:0] prs2;
        logic          rs2_rdy;
        logic          uses_imm;
        logic [31:0]   imm;
    } rs_row_t;
endpackage

interface dispatch_unit_if;
    import dispatch_unit_pkg::*;

    logic                 stall;
    rename_t [1:0]        rename_data;
    logic [1:0]           wb_valid;
    logic [1:0][PW-1:0]   wb_preg;
    rob_row_t [1:0]       rob_rows;
    rs_row_t [1:0]        rs_rows;
    logic [RW-1:0]        rob_tail;

    modport master (output stall, rename_data, wb_valid, wb_preg,
                    input  rob_rows, rs_rows, rob_tail);
    modport slave  (input  stall, rename_data, wb_valid, wb_preg,
                    output rob_rows, rs_rows, rob_tail);
endinterface

// File: rtl/dispatch_unit.sv
// Two-wide dispatch: allocates consecutive ROB indices and resolves operand readiness
// from a physical-register busy table with intra-bundle and writeback bypass.
module dispatch_unit
    import dispatch_unit_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    dispatch_unit_if.slave bus
);

    logic [NUM_PREGS-1:0] busy;
    logic [NUM_PREGS-1:0] busy_n;
    logic [RW-1:0]        tail;
    logic [RW-1:0]        idx;
    rob_row_t [1:0]       rob_n;
    rs_row_t [1:0]        rs_n;
    rename_t              cur;
    logic                 dep;

    // Priority: unused/preg0, then same-bundle producer, then wakeup, then busy table.
    function automatic logic src_ready(input logic used, input logic [PW-1:0] p,
                                       input logic dep_hit, input logic [1:0] wbv,
                                       input logic [1:0][PW-1:0] wbp, input logic bsy);
        if (!used || p == '0) return 1'b1;
        if (dep_hit) return 1'b0;
        if ((wbv[0] && wbp[0] == p) || (wbv[1] && wbp[1] == p)) return 1'b1;
        return !bsy;
    endfunction

    always_comb begin
        rob_n  = '0;
        rs_n   = '0;
        busy_n = busy;
        idx    = tail;
        cur    = '0;
        dep    = 1'b0;
        for (int w = 0; w < 2; w++) begin
            if (bus.wb_valid[w]) busy_n[bus.wb_preg[w]] = 1'b0;
        end
        // Sets follow clears so a same-cycle reallocation keeps the preg busy.
        if (!bus.stall) begin
            for (int s = 0; s < 2; s++) begin
                cur = bus.rename_data[s];
                dep = (s == 1) && bus.rename_data[0].valid && bus.rename_data[0].writes_rd;
                if (cur.valid) begin
                    rob_n[s].valid     = 1'b1;
                    rob_n[s].rob_idx   = idx;
                    rob_n[s].arch_rd   = cur.arch_rd;
                    rob_n[s].prd       = cur.prd;
                    rob_n[s].old_prd   = cur.old_prd;
                    rob_n[s].writes_rd = cur.writes_rd;
                    rob_n[s].done      = 1'b0;
                    rs_n[s].valid      = 1'b1;
                    rs_n[s].rob_idx    = idx;
                    rs_n[s].op         = cur.op;
                    rs_n[s].fu         = cur.fu;
                    rs_n[s].prd        = cur.prd;
                    rs_n[s].prs1       = cur.prs1;
                    rs_n[s].prs2       = cur.prs2;
                    rs_n[s].uses_imm   = cur.uses_imm;
                    rs_n[s].imm        = cur.imm;
                    rs_n[s].rs1_rdy    = src_ready(cur.uses_rs1, cur.prs1,
                                             dep && cur.prs1 == bus.rename_data[0].prd,
                                             bus.wb_valid, bus.wb_preg, busy[cur.prs1]);
                    rs_n[s].rs2_rdy    = src_ready(cur.uses_rs2, cur.prs2,
                                             dep && cur.prs2 == bus.rename_data[0].prd,
                                             bus.wb_valid, bus.wb_preg, busy[cur.prs2]);
                    idx = idx + RW'(1);
                    if (cur.writes_rd && cur.prd != '0) busy_n[cur.prd] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy         <= '0;
            tail         <= '0;
            bus.rob_rows <= '0;
            bus.rs_rows  <= '0;
        end else begin
            busy         <= busy_n;
            tail         <= idx;
            bus.rob_rows <= rob_n;
            bus.rs_rows  <= rs_n;
        end
    end

    assign bus.rob_tail = tail;

endmodule

// File: tb/tb_dispatch_unit.sv
// Directed bench for dispatch_unit: ROB indexing, tail wrap, readiness bypasses, stall and reset.
module tb_dispatch_unit;
    import dispatch_unit_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    dispatch_unit_if bus ();

    dispatch_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic rename_t mk(input logic v, input logic [5:0] prd, input logic w,
                                   input logic [5:0] p1, input logic u1,
                                   input logic [5:0] p2, input logic u2);
        rename_t r;
        r           = '0;
        r.valid     = v;
        r.op        = 6'h15;
        r.fu        = 2'd2;
        r.arch_rd   = prd[4:0];
        r.writes_rd = w;
        r.prd       = prd;
        r.old_prd   = prd ^ 6'h20;
        r.prs1      = p1;
        r.uses_rs1  = u1;
        r.prs2      = p2;
        r.uses_rs2  = u2;
        r.uses_imm  = !u2;
        r.imm       = 32'h1000 + {26'h0, prd};
        return r;
    endfunction

    task automatic drive(input rename_t r0, input rename_t r1);
        bus.rename_data[0] = r0;
        bus.rename_data[1] = r1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        bus.wb_valid = 2'b00;
        bus.stall    = 1'b0;
    endtask

    function automatic logic [3:0] rdy4();
        return {bus.rs_rows[0].rs1_rdy, bus.rs_rows[0].rs2_rdy,
                bus.rs_rows[1].rs1_rdy, bus.rs_rows[1].rs2_rdy};
    endfunction

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        bus.stall      = 1'b0;
        bus.wb_valid   = 2'b00;
        bus.wb_preg[0] = '0;
        bus.wb_preg[1] = '0;
        drive('0, '0);
        #12;
        check("rst_rob_valid", {bus.rob_rows[1].valid, bus.rob_rows[0].valid}, 2'b00);
        check("rst_rs_valid", {bus.rs_rows[1].valid, bus.rs_rows[0].valid}, 2'b00);
        check("rst_tail", bus.rob_tail, 4'd0);
        check("rst_rs_imm", bus.rs_rows[0].imm, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Independent pair
        drive(mk(1, 6'd10, 1, 6'd3, 1, 6'd4, 1), mk(1, 6'd11, 1, 6'd3, 1, 6'd4, 1));
        step();
        check("b1_idx0", bus.rob_rows[0].rob_idx, 4'd0);
        check("b1_idx1", bus.rs_rows[1].rob_idx, 4'd1);
        check("b1_rdy", rdy4(), 4'b1111);
        check("b1_tail", bus.rob_tail, 4'd2);
        check("b1_valid", {bus.rob_rows[1].valid, bus.rs_rows[0].valid}, 2'b11);
        check("b1_arch_rd", bus.rob_rows[0].arch_rd, 5'd10);
        check("b1_old_prd", bus.rob_rows[1].old_prd, 6'd43);
        check("b1_done", bus.rob_rows[0].done, 1'b0);
        check("b1_imm", bus.rs_rows[0].imm, 32'h100a);
        check("b1_op_fu", {bus.rs_rows[1].op, bus.rs_rows[1].fu}, {6'h15, 2'd2});

        // Busy readers plus intra-bundle dependence on 13
        drive(mk(1, 6'd13, 1, 6'd10, 1, 6'd0, 0), mk(1, 6'd14, 1, 6'd13, 1, 6'd3, 1));
        step();
        check("b2_rdy", rdy4(), 4'b0101);
        check("b2_idx", {bus.rs_rows[0].rob_idx, bus.rs_rows[1].rob_idx}, {4'd2, 4'd3});
        check("b2_tail", bus.rob_tail, 4'd4);

        // Wakeup of 10 bypasses into the same-cycle reader; 11 still busy
        drive(mk(1, 6'd15, 1, 6'd10, 1, 6'd0, 0), mk(1, 6'd16, 1, 6'd11, 1, 6'd0, 0));
        bus.wb_valid   = 2'b01;
        bus.wb_preg[0] = 6'd10;
        step();
        check("b3_rdy", rdy4(), 4'b1101);
        check("b3_tail", bus.rob_tail, 4'd6);

        drive(mk(1, 6'd0, 0, 6'd10, 1, 6'd0, 0), mk(1, 6'd0, 0, 6'd13, 1, 6'd14, 1));
        step();
        check("b4_rdy", rdy4(), 4'b1100);
        check("b4_tail", bus.rob_tail, 4'd8);

        drive(mk(1, 6'd12, 1, 6'd0, 0, 6'd0, 0), mk(1, 6'd0, 0, 6'd0, 0, 6'd0, 0));
        step();
        check("b5_tail", bus.rob_tail, 4'd10);

        // Wakeup of 12 on port 1 with reader, while slot1 reallocates 12
        drive(mk(1, 6'd0, 0, 6'd12, 1, 6'd0, 0), mk(1, 6'd12, 1, 6'd0, 0, 6'd0, 0));
        bus.wb_valid   = 2'b10;
        bus.wb_preg[1] = 6'd12;
        step();
        check("b6_bypass", bus.rs_rows[0].rs1_rdy, 1'b1);
        check("b6_tail", bus.rob_tail, 4'd12);

        drive(mk(1, 6'd0, 0, 6'd12, 1, 6'd0, 0), mk(0, 6'd0, 0, 6'd0, 0, 6'd0, 0));
        step();
        check("b7_set_wins", bus.rs_rows[0].rs1_rdy, 1'b0);
        check("b7_slot1_inv", {bus.rob_rows[1].valid, bus.rs_rows[1].valid}, 2'b00);
        check("b7_tail", bus.rob_tail, 4'd13);

        // Stall: nothing allocated, wakeup of 12 still applied, prd 20 not marked
        drive(mk(1, 6'd20, 1, 6'd0, 0, 6'd0, 0), mk(1, 6'd21, 1, 6'd0, 0, 6'd0, 0));
        bus.stall      = 1'b1;
        bus.wb_valid   = 2'b01;
        bus.wb_preg[0] = 6'd12;
        step();
        check("stall_valid", {bus.rob_rows[1].valid, bus.rob_rows[0].valid,
                              bus.rs_rows[1].valid, bus.rs_rows[0].valid}, 4'b0000);
        check("stall_tail", bus.rob_tail, 4'd13);

        drive(mk(1, 6'd0, 0, 6'd12, 1, 6'd20, 1), mk(1, 6'd0, 0, 6'd11, 1, 6'd21, 1));
        step();
        check("post_stall_rdy", rdy4(), 4'b1101);
        check("post_stall_idx", {bus.rob_rows[0].rob_idx, bus.rob_rows[1].rob_idx}, {4'd13, 4'd14});
        check("post_stall_tail", bus.rob_tail, 4'd15);

        // Asynchronous reset mid-stream
        rst_n = 1'b0;
        #1;
        check("arst_valid", {bus.rob_rows[0].valid, bus.rs_rows[1].valid}, 2'b00);
        check("arst_tail", bus.rob_tail, 4'd0);
        #1;
        rst_n = 1'b1;

        // Eight 2-wide bundles; first one also confirms busy was cleared
        for (int b = 0; b < 8; b++) begin
            drive(mk(1, 6'd0, 0, 6'd11, 1, 6'd13, 1), mk(1, 6'd0, 0, 6'd15, 1, 6'd12, 1));
            step();
            if (b == 0) check("arst_busy_clr", rdy4(), 4'b1111);
            check($sformatf("wrap_idx_%0d", b),
                  {bus.rob_rows[0].rob_idx, bus.rob_rows[1].rob_idx},
                  {4'(2 * b), 4'(2 * b + 1)});
        end
        check("wrap_tail", bus.rob_tail, 4'd0);

        drive(mk(1, 6'd0, 0, 6'd0, 0, 6'd0, 0), mk(0, 6'd0, 0, 6'd0, 0, 6'd0, 0));
        step();
        check("s0only_idx", bus.rob_rows[0].rob_idx, 4'd0);
        check("s0only_tail", bus.rob_tail, 4'd1);

        drive(mk(0, 6'd0, 0, 6'd0, 0, 6'd0, 0), mk(1, 6'd22, 1, 6'd0, 0, 6'd0, 0));
        step();
        check("s1only_valid", {bus.rob_rows[0].valid, bus.rob_rows[1].valid}, 2'b01);
        check("s1only_idx", bus.rs_rows[1].rob_idx, 4'd1);
        check("s1only_tail", bus.rob_tail, 4'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
